serial_sync_tx: RTL
===================

# serial_sync_tx

Serial frame transmitter that drives a single-bit line with a fixed 1-0-0-1 sync marker, a parallel data word shifted out MSB first, and an optional even-parity bit. It is the sending side of the team's 1001-marker serial link. Downstream sync detectors lock on the marker, and data is recovered from the bits that follow it. It accepts one word per frame through a ready/start handshake and supports back-to-back frames with no idle gap.

## Interface
- DATA_W, 8: payload width in bits, minimum 1
- PARITY_EN, 1: 1 appends an even-parity bit after the payload; 0 omits it
- clock  input  1  single clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock
- start  input  1  request to send; accepted only on a rising edge where ready=1
- data  input  DATA_W  payload word; captured on the accepting edge
- X  output  1  serial line, registered; 0 when idle
- ready  output  1  transmitter can accept start on the next edge
- done  output  1  one-cycle pulse coinciding with the last bit of a frame

## Operation
- States: IDLE, SYNC, DATA, PAR. Encoding is free. Unused codes go to IDLE.
- IDLE: X=0, ready=1, done=0.
  - start=1 captures data into the shift register, computes parity as the XOR of all bits, and moves to SYNC with bit index 0.
  - start=0 stays in IDLE.
- SYNC: X follows the marker 1,0,0,1, one bit per cycle, using a 2-bit index. After the 4th marker bit it moves to DATA.
- DATA: X = shift-register MSB; the register shifts left each cycle. A counter runs 0..DATA_W-1. After bit DATA_W-1:
  - PARITY_EN=1: move to PAR.
  - PARITY_EN=0: end of frame.
- PAR: X = captured parity bit (even parity, so the total count of 1s in payload plus parity is even). Then end of frame.
- Last-bit cycle (PAR, or the final DATA bit when PARITY_EN=0):
  - done=1 and ready=1.
  - start=1 on the closing edge: capture the new data and go straight to SYNC. The next marker bit follows the last bit with no gap.
  - start=0: return to IDLE.
- start while ready=0 is ignored; no queuing.
- Changes on data after the accepting edge have no effect on the frame in flight.
- Frame length: 4 + DATA_W + PARITY_EN bits (13 at defaults).

## Timing
- Reset: on an edge with reset=1 the block goes to IDLE. After that edge X=0, ready=1, done=0, and the shift register, counters and parity are cleared.
- Reset overrides start on the same edge.
- Reset mid-frame aborts the frame. X=0 from the next cycle, and no done pulse is issued.
- Latency: start accepted at edge N gives X=1 (first marker bit) in cycle N+1.
  - Marker occupies cycles N+1..N+4.
  - Payload MSB is in cycle N+5; payload LSB in cycle N+4+DATA_W.
  - Parity, if enabled, in cycle N+5+DATA_W.
- ready=0 from the cycle after acceptance until the last-bit cycle, where it rises again.
- done is high for exactly one cycle per completed frame, aligned with the last bit.
- Sustained back-to-back throughput: one frame per 4+DATA_W+PARITY_EN cycles.
- X, ready and done are all registered outputs; no combinational path from start or data.

## Test plan
- Reset then idle: hold reset 2 cycles with start=1 -> X=0, ready=1, done=0, no frame emitted. Release with start=0 for 10 cycles -> X stays 0.
- Single frame at defaults: data=8'hA5, start pulse at edge N -> X over cycles N+1..N+13 = 1,0,0,1, 1,0,1,0,0,1,0,1, 0. done=1 only in cycle N+13. ready=0 during N+1..N+12.
- Odd parity payload: data=8'h01 -> payload 0,0,0,0,0,0,0,1 then parity bit 1. Changing data to 8'hFF at N+3 leaves the frame unchanged.
- Back-to-back: start held high, data=8'h0F then 8'hF0 -> two 13-bit frames with no gap. The second frame's marker 1 appears in cycle N+14. done pulses at N+13 and N+26.
- Ignored start and abort: pulse start at N+6 mid-frame -> no effect. Assert reset at N+8 -> X=0 from N+9, no done pulse, ready=1.
- PARITY_EN=0, DATA_W=4: data=4'b1001 -> X = 1,0,0,1,1,0,0,1 over 8 cycles. done is on the 8th bit. A 1001 detector bench model flags the marker at bit 4 and again at bit 8 (the payload).

Source files
------------

// File: rtl/serial_sync_tx.sv
// serial_sync_tx: serial frame transmitter for the 1001-marker link.
// Each frame is the marker 1,0,0,1, then DATA_W payload bits MSB first,
// then an optional even-parity bit. One word is accepted per frame
// through a ready/start handshake. A new frame may start on the closing
// edge of the previous one, so frames can run back to back with no gap.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high reset
//   start  - send request, accepted on an edge where ready=1
//   data   - payload word, captured on the accepting edge
//   X      - registered serial line, 0 when idle
//   ready  - registered; transmitter accepts start on the next edge
//   done   - registered one-cycle pulse aligned with the last frame bit
module serial_sync_tx #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY_EN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              X,
  output logic              ready,
  output logic              done
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic [3:0] MARKER = 4'b1001;
  localparam bit HAS_PAR = (PARITY_EN != 0);
  // A 1-bit payload without parity makes the first data bit the last bit.
  localparam bit FIRST_DATA_IS_LAST = (DATA_W == 1) && !HAS_PAR;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    PAR  = 2'd3
  } state_t;

  state_t            state;
  logic [1:0]        sync_idx;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              parity;
  logic [DATA_W-1:0] shreg_sh;
  logic              frame_end;
  logic              can_accept;
  logic              next_is_last;

  assign shreg_sh = shreg << 1;

  // Current cycle carries the last bit of a frame.
  assign frame_end = (state == PAR) ||
                     ((state == DATA) && (bit_cnt == LAST_IDX) && !HAS_PAR);
  assign can_accept = (state == IDLE) || frame_end;

  // The upcoming DATA bit closes the frame (parity disabled only).
  assign next_is_last = !HAS_PAR && ((bit_cnt + CNT_W'(1)) == LAST_IDX);

  // Frame sequencer; outputs are registered alongside the state so that
  // X/ready/done describe the bit being driven in the following cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      sync_idx <= 2'd0;
      bit_cnt  <= '0;
      shreg    <= '0;
      parity   <= 1'b0;
      X        <= 1'b0;
      ready    <= 1'b1;
      done     <= 1'b0;
    end else if (can_accept && start) begin
      state    <= SYNC;
      sync_idx <= 2'd0;
      bit_cnt  <= '0;
      shreg    <= data;
      parity   <= ^data;
      X        <= MARKER[3];
      ready    <= 1'b0;
      done     <= 1'b0;
    end else if (can_accept) begin
      state <= IDLE;
      X     <= 1'b0;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      case (state)
        SYNC: begin
          if (sync_idx == 2'd3) begin
            state   <= DATA;
            bit_cnt <= '0;
            X       <= shreg[DATA_W-1];
            ready   <= FIRST_DATA_IS_LAST;
            done    <= FIRST_DATA_IS_LAST;
          end else begin
            sync_idx <= sync_idx + 2'd1;
            // Marker is sent MSB first; idx k is on the line now, k+1 next.
            X        <= MARKER[2'd2 - sync_idx];
            ready    <= 1'b0;
            done     <= 1'b0;
          end
        end
        DATA: begin
          if (bit_cnt == LAST_IDX) begin
            // Only reached with parity enabled; otherwise frame_end caught it.
            state <= PAR;
            X     <= parity;
            ready <= 1'b1;
            done  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            shreg   <= shreg_sh;
            X       <= shreg_sh[DATA_W-1];
            ready   <= next_is_last;
            done    <= next_is_last;
          end
        end
        default: begin
          state <= IDLE;
          X     <= 1'b0;
          ready <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
